cdb_reservation_station: RTL and testbench
==========================================

CDB_RESERVATION_STATION -- requirements
Module: cdb_reservation_station

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset, both listed in the port list below.
REQ-002 The block SHALL have these parameters:
- DEPTH, default 4, number of entries.
- TAG_WIDTH, default 6, width of a CDB tag.
- DATA_WIDTH, default 32, width of operands and CDB data.
- OP_WIDTH, default 5, width of the ALU opcode.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all entries.
- dispatch_valid  in  1  a dispatch request is present.
- dispatch_ready  out  1  the block accepts a dispatch this cycle.
- dispatch_op  in  OP_WIDTH  opcode.
- dispatch_dst_tag  in  TAG_WIDTH  result tag.
- dispatch_src1_ready, dispatch_src2_ready  in  1 each  operand value is valid.
- dispatch_src1_tag, dispatch_src2_tag  in  TAG_WIDTH each  producer tag when the operand is not ready.
- dispatch_src1_data, dispatch_src2_data  in  DATA_WIDTH each  operand value when ready.
- cdb_valid  in  1  CDB broadcast is valid.
- cdb_tag  in  TAG_WIDTH  CDB producer tag.
- cdb_data  in  DATA_WIDTH  CDB result.
- issue_valid  out  1  an issue is presented.
- issue_ready  in  1  the ALU accepts the issue.
- issue_op  out  OP_WIDTH  opcode of the issued entry.
- issue_dst_tag  out  TAG_WIDTH  result tag of the issued entry.
- issue_src1, issue_src2  out  DATA_WIDTH each  operand values of the issued entry.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-004 Each entry SHALL hold: valid, op, dst_tag, and for each source a ready bit, a tag and a value.
REQ-005 dispatch_ready SHALL equal (occupancy < DEPTH) & !flush & rst_n; an entry freed in the same cycle SHALL NOT count toward this.
REQ-006 On dispatch_valid & dispatch_ready, the request SHALL be written into the lowest-index invalid entry at the next clock edge.
REQ-007 Dispatch bypass: for a source with ready=0, if cdb_valid and cdb_tag equals that source's tag in the dispatch cycle, the source SHALL be stored ready with value cdb_data.
REQ-008 Snoop: for every valid entry and every source with ready=0, if cdb_valid and cdb_tag equals the stored tag, the source SHALL become ready with value cdb_data at the next edge; both sources of one entry MAY wake in the same cycle.
REQ-009 Sources already ready SHALL never be overwritten by the CDB.
REQ-010 An entry SHALL be eligible for issue when it is valid and both sources are ready in registered state; there is no same-cycle path from the CDB to issue, so minimum wakeup-to-issue_valid latency is 1 cycle.
REQ-011 Dispatch-to-issue_valid latency SHALL be at least 1 cycle; a fully ready dispatch at edge N presents issue_valid in cycle N+1.
REQ-012 Selection SHALL pick the oldest eligible entry in dispatch order, with the age order kept across wrap of entry indices.
REQ-013 issue_* outputs SHALL be driven from registered state only.
REQ-014 Handshake:
- Once issue_valid is asserted with issue_ready low, the selected entry and all issue_* outputs SHALL remain stable until accepted, even if an older entry becomes eligible.
- On issue_valid & issue_ready, the entry SHALL be invalidated at the next edge.
REQ-015 When no entry is eligible, issue_valid SHALL be 0 and the other issue_* outputs SHALL be 0.
REQ-016 occupancy SHALL be updated at each edge as +1 on dispatch, -1 on issue, and unchanged when both occur.
REQ-017 Flush:
- While flush is high, issue_valid and dispatch_ready SHALL be 0.
- At the next edge all entries SHALL become invalid and occupancy SHALL be 0.
- Flush SHALL take priority over dispatch, issue and snoop.
REQ-018 When cdb_valid=0, cdb_tag and cdb_data SHALL be ignored.

Reset
REQ-019 While rst_n=0 at a rising edge, all entries SHALL become invalid, occupancy SHALL be 0, and the issue lock SHALL clear.
REQ-020 While rst_n=0, issue_valid, dispatch_ready and all issue_* outputs SHALL read 0.
REQ-021 Reset asserted mid-operation SHALL discard pending entries with no issue handshake completing in that cycle.
REQ-022 dispatch_ready SHALL be 1 in the first cycle with rst_n=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Dispatch op=3, dst=5, src1 ready=0x10, src2 ready=0x20, issue_ready=1 -> next cycle issue_valid=1, issue_dst_tag=5, issue_src1=0x10, issue_src2=0x20; occupancy 1 then 0.
- Dispatch with src1 tag 7 not ready; 2 cycles later cdb_valid, tag=7, data=0xDEAD -> issue_valid=1 the following cycle with issue_src1=0xDEAD.
- Same-cycle bypass: dispatch with src2 tag 9 not ready while cdb_valid, tag=9, data=0x55 -> issue_valid next cycle with issue_src2=0x55.
- Fill 4 entries (dst 1..4, all ready), issue_ready=0 -> dispatch_ready=0, occupancy=4, issue_dst_tag holds 1; then issue_ready=1 -> issues dst 1,2,3,4 on consecutive cycles.
- Entry A (dst 1) waits on tag 8, entry B (dst 2) ready and stalled; CDB tag 8 arrives -> issue stays dst 2 until accepted, then dst 1.
- 3 entries valid, flush pulse -> next cycle occupancy=0, issue_valid=0; repeat with rst_n=0 -> same result and dispatch_ready=0 during reset.

Source files
------------

// File: rtl/cdb_reservation_station.sv
// Reservation station that holds dispatched ALU ops until both operands are
// ready. Operands arrive at dispatch, through a same-cycle CDB bypass, or by
// snooping the CDB. Issue picks the oldest eligible entry in dispatch order.
//
// Handshakes (both strict valid/ready): a transfer happens on a rising edge
// where valid & ready are both high. dispatch_ready depends only on registered
// occupancy, flush and rst_n. Once issue_valid is shown with issue_ready low,
// the selected entry is locked and the issue_* outputs hold until accepted.
module cdb_reservation_station #(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [OP_WIDTH-1:0]        dispatch_op,
  input  logic [TAG_WIDTH-1:0]       dispatch_dst_tag,
  input  logic                       dispatch_src1_ready,
  input  logic                       dispatch_src2_ready,
  input  logic [TAG_WIDTH-1:0]       dispatch_src1_tag,
  input  logic [TAG_WIDTH-1:0]       dispatch_src2_tag,
  input  logic [DATA_WIDTH-1:0]      dispatch_src1_data,
  input  logic [DATA_WIDTH-1:0]      dispatch_src2_data,
  input  logic                       cdb_valid,
  input  logic [TAG_WIDTH-1:0]       cdb_tag,
  input  logic [DATA_WIDTH-1:0]      cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [OP_WIDTH-1:0]        issue_op,
  output logic [TAG_WIDTH-1:0]       issue_dst_tag,
  output logic [DATA_WIDTH-1:0]      issue_src1,
  output logic [DATA_WIDTH-1:0]      issue_src2,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [OP_WIDTH-1:0]   op_q [DEPTH];
  logic [OP_WIDTH-1:0]   op_d [DEPTH];
  logic [TAG_WIDTH-1:0]  dst_q [DEPTH];
  logic [TAG_WIDTH-1:0]  dst_d [DEPTH];
  logic [TAG_WIDTH-1:0]  s1_tag_q [DEPTH];
  logic [TAG_WIDTH-1:0]  s1_tag_d [DEPTH];
  logic [TAG_WIDTH-1:0]  s2_tag_q [DEPTH];
  logic [TAG_WIDTH-1:0]  s2_tag_d [DEPTH];
  logic [DATA_WIDTH-1:0] s1_val_q [DEPTH];
  logic [DATA_WIDTH-1:0] s1_val_d [DEPTH];
  logic [DATA_WIDTH-1:0] s2_val_q [DEPTH];
  logic [DATA_WIDTH-1:0] s2_val_d [DEPTH];
  // older_q[j][i] set means entry j was dispatched before entry i; this keeps
  // age order independent of entry index, so it survives index wrap.
  logic [DEPTH-1:0]      older_q [DEPTH];
  logic [DEPTH-1:0]      older_d [DEPTH];
  logic                  lock_q, lock_d;
  logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic [DEPTH-1:0]      elig;
  logic                  oldest_found, free_found;
  logic [IDX_W-1:0]      oldest_idx, free_idx, sel_idx;
  logic                  sel_ok, issue_fire, disp_fire;

  // Oldest eligible entry: eligible and no other eligible entry is older.
  always_comb begin : pick_oldest
    logic blocked;
    elig         = valid_q & s1_rdy_q & s2_rdy_q;
    oldest_found = 1'b0;
    oldest_idx   = '0;
    blocked      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        if (elig[j] && older_q[j][i]) blocked = 1'b1;
      if (elig[i] && !blocked && !oldest_found) begin
        oldest_found = 1'b1;
        oldest_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest-index free entry for the next dispatch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
  end

  // Handshake outputs and issue payload, all from registered state.
  always_comb begin
    sel_ok         = lock_q | oldest_found;
    sel_idx        = lock_q ? lock_idx_q : oldest_idx;
    issue_valid    = sel_ok & ~flush & rst_n;
    dispatch_ready = (occ_q < OCC_W'(DEPTH)) & ~flush & rst_n;
    issue_fire     = issue_valid & issue_ready;
    disp_fire      = dispatch_valid & dispatch_ready & free_found;
    issue_op       = '0;
    issue_dst_tag  = '0;
    issue_src1     = '0;
    issue_src2     = '0;
    if (issue_valid) begin
      issue_op      = op_q[sel_idx];
      issue_dst_tag = dst_q[sel_idx];
      issue_src1    = s1_val_q[sel_idx];
      issue_src2    = s2_val_q[sel_idx];
    end
  end

  assign occupancy = occ_q;

  // Next state: snoop, issue retire, dispatch write, lock, occupancy, flush.
  always_comb begin
    valid_d    = valid_q;
    s1_rdy_d   = s1_rdy_q;
    s2_rdy_d   = s2_rdy_q;
    op_d       = op_q;
    dst_d      = dst_q;
    s1_tag_d   = s1_tag_q;
    s2_tag_d   = s2_tag_q;
    s1_val_d   = s1_val_q;
    s2_val_d   = s2_val_q;
    older_d    = older_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    occ_d      = occ_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (!s1_rdy_q[i] && (s1_tag_q[i] == cdb_tag)) begin
          s1_rdy_d[i] = 1'b1;
          s1_val_d[i] = cdb_data;
        end
        if (!s2_rdy_q[i] && (s2_tag_q[i] == cdb_tag)) begin
          s2_rdy_d[i] = 1'b1;
          s2_val_d[i] = cdb_data;
        end
      end
    end

    if (issue_fire) valid_d[sel_idx] = 1'b0;

    if (disp_fire) begin
      valid_d[free_idx]  = 1'b1;
      op_d[free_idx]     = dispatch_op;
      dst_d[free_idx]    = dispatch_dst_tag;
      s1_rdy_d[free_idx] = dispatch_src1_ready;
      s1_tag_d[free_idx] = dispatch_src1_tag;
      s1_val_d[free_idx] = dispatch_src1_data;
      s2_rdy_d[free_idx] = dispatch_src2_ready;
      s2_tag_d[free_idx] = dispatch_src2_tag;
      s2_val_d[free_idx] = dispatch_src2_data;
      if (!dispatch_src1_ready && cdb_valid && (dispatch_src1_tag == cdb_tag)) begin
        s1_rdy_d[free_idx] = 1'b1;
        s1_val_d[free_idx] = cdb_data;
      end
      if (!dispatch_src2_ready && cdb_valid && (dispatch_src2_tag == cdb_tag)) begin
        s2_rdy_d[free_idx] = 1'b1;
        s2_val_d[free_idx] = cdb_data;
      end
      // Everything already resident is older than the new entry.
      for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = valid_q[j];
      older_d[free_idx] = '0;
    end

    if (issue_fire) begin
      lock_d = 1'b0;
    end else if (issue_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end

    occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);

    if (flush) begin
      valid_d = '0;
      lock_d  = 1'b0;
      occ_d   = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      s1_rdy_q   <= '0;
      s2_rdy_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      occ_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]     <= '0;
        dst_q[i]    <= '0;
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        s1_val_q[i] <= '0;
        s2_val_q[i] <= '0;
        older_q[i]  <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      s1_rdy_q   <= s1_rdy_d;
      s2_rdy_q   <= s2_rdy_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      occ_q      <= occ_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      s1_tag_q   <= s1_tag_d;
      s2_tag_q   <= s2_tag_d;
      s1_val_q   <= s1_val_d;
      s2_val_q   <= s2_val_d;
      older_q    <= older_d;
    end
  end
endmodule

// File: tb/tb_cdb_reservation_station.sv
// Directed bench for cdb_reservation_station with hand-computed expectations.
module tb_cdb_reservation_station;
  localparam int DEPTH = 4;
  localparam int TW    = 6;
  localparam int DW    = 32;
  localparam int OW    = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n, flush;
  logic          dispatch_valid, dispatch_ready;
  logic [OW-1:0] dispatch_op;
  logic [TW-1:0] dispatch_dst_tag, dispatch_src1_tag, dispatch_src2_tag;
  logic          dispatch_src1_ready, dispatch_src2_ready;
  logic [DW-1:0] dispatch_src1_data, dispatch_src2_data;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          issue_valid, issue_ready;
  logic [OW-1:0] issue_op;
  logic [TW-1:0] issue_dst_tag;
  logic [DW-1:0] issue_src1, issue_src2;
  logic [CW-1:0] occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  cdb_reservation_station #(
    .DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .OP_WIDTH(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_dst_tag(dispatch_dst_tag),
    .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src2_ready(dispatch_src2_ready),
    .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
    .dispatch_src1_data(dispatch_src1_data), .dispatch_src2_data(dispatch_src2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
    .issue_src1(issue_src1), .issue_src2(issue_src2),
    .occupancy(occupancy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [OW-1:0] op, input logic [TW-1:0] dst,
                          input logic r1, input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                          input logic r2, input logic [TW-1:0] t2, input logic [DW-1:0] d2);
    dispatch_valid      = 1'b1;
    dispatch_op         = op;
    dispatch_dst_tag    = dst;
    dispatch_src1_ready = r1;
    dispatch_src1_tag   = t1;
    dispatch_src1_data  = d1;
    dispatch_src2_ready = r2;
    dispatch_src2_tag   = t2;
    dispatch_src2_data  = d2;
  endtask

  task automatic clr_disp();
    dispatch_valid = 1'b0;
  endtask

  task automatic set_cdb(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    set_disp('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    clr_disp();
    set_cdb(1'b0, '0, '0);

    // Reset state
    tick(); tick();
    #1;
    check_eq("rst_drdy", dispatch_ready, 0);
    check_eq("rst_ivalid", issue_valid, 0);
    check_eq("rst_occ", occupancy, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("first_drdy", dispatch_ready, 1);

    // S1: fully ready dispatch issues next cycle
    issue_ready = 1'b1;
    set_disp(5'd3, 6'd5, 1'b1, '0, 32'h10, 1'b1, '0, 32'h20);
    tick(); clr_disp(); #1;
    check_eq("s1_ivalid", issue_valid, 1);
    check_eq("s1_op", issue_op, 3);
    check_eq("s1_dst", issue_dst_tag, 5);
    check_eq("s1_src1", issue_src1, 32'h10);
    check_eq("s1_src2", issue_src2, 32'h20);
    check_eq("s1_occ1", occupancy, 1);
    tick(); #1;
    check_eq("s1_occ0", occupancy, 0);
    check_eq("s1_idle_valid", issue_valid, 0);
    check_eq("s1_idle_src1", issue_src1, 0);
    check_eq("s1_idle_dst", issue_dst_tag, 0);

    // S2: wakeup by CDB two cycles after dispatch; invalid CDB ignored
    set_disp(5'd4, 6'd6, 1'b0, 6'd7, '0, 1'b1, '0, 32'h2);
    tick(); clr_disp(); set_cdb(1'b0, 6'd7, 32'hBAD); #1;
    check_eq("s2_wait_valid", issue_valid, 0);
    check_eq("s2_occ", occupancy, 1);
    tick(); set_cdb(1'b1, 6'd7, 32'hDEAD); #1;
    check_eq("s2_cdb_cycle_valid", issue_valid, 0);
    tick(); set_cdb(1'b0, '0, '0); #1;
    check_eq("s2_ivalid", issue_valid, 1);
    check_eq("s2_src1", issue_src1, 32'hDEAD);
    check_eq("s2_dst", issue_dst_tag, 6);
    tick(); #1;
    check_eq("s2_occ0", occupancy, 0);

    // S3: same-cycle bypass at dispatch
    set_disp(5'd2, 6'd10, 1'b1, '0, 32'h1, 1'b0, 6'd9, '0);
    set_cdb(1'b1, 6'd9, 32'h55);
    tick(); clr_disp(); set_cdb(1'b0, '0, '0); #1;
    check_eq("s3_ivalid", issue_valid, 1);
    check_eq("s3_src2", issue_src2, 32'h55);
    check_eq("s3_src1", issue_src1, 32'h1);
    tick(); #1;
    check_eq("s3_occ0", occupancy, 0);

    // S4: fill, stall, drain in order
    issue_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_disp(OW'(k), TW'(k), 1'b1, '0, DW'(k * 16), 1'b1, '0, DW'(k * 16 + 1));
      #1;
      check_eq("s4_fill_drdy", dispatch_ready, 1);
      tick();
    end
    set_disp(5'd15, 6'd15, 1'b1, '0, 32'hF0, 1'b1, '0, 32'hF1);
    issue_ready = 1'b1;
    #1;
    check_eq("s4_full_drdy", dispatch_ready, 0);
    check_eq("s4_full_occ", occupancy, 4);
    check_eq("s4_hold_dst", issue_dst_tag, 1);
    check_eq("s4_hold_src1", issue_src1, 32'h10);
    tick(); clr_disp();
    for (int k = 2; k <= 4; k++) begin
      #1;
      check_eq("s4_drain_dst", issue_dst_tag, TW'(k));
      check_eq("s4_drain_occ", occupancy, CW'(5 - k));
      tick();
    end
    #1;
    check_eq("s4_empty_valid", issue_valid, 0);
    check_eq("s4_empty_occ", occupancy, 0);

    // S5: stalled younger ready entry holds while older one wakes
    issue_ready = 1'b0;
    set_disp(5'd1, 6'd1, 1'b0, 6'd8, '0, 1'b1, '0, 32'h22);
    tick();
    set_disp(5'd2, 6'd2, 1'b1, '0, 32'hB1, 1'b1, '0, 32'hB2);
    tick(); clr_disp();
    set_cdb(1'b1, 6'd8, 32'h88);
    #1;
    check_eq("s5_first_dst", issue_dst_tag, 2);
    tick(); set_cdb(1'b1, 6'd8, 32'h99); #1;
    check_eq("s5_lock_dst", issue_dst_tag, 2);
    tick(); set_cdb(1'b0, '0, '0); #1;
    check_eq("s5_lock_dst2", issue_dst_tag, 2);
    check_eq("s5_lock_src1", issue_src1, 32'hB1);
    issue_ready = 1'b1;
    tick(); #1;
    check_eq("s5_next_dst", issue_dst_tag, 1);
    check_eq("s5_next_src1", issue_src1, 32'h88);
    check_eq("s5_next_src2", issue_src2, 32'h22);
    tick(); #1;
    check_eq("s5_empty_valid", issue_valid, 0);

    // S6: age order across index wrap; one CDB wakes two entries and two sources
    set_disp(5'd20, 6'd20, 1'b1, '0, 32'h1, 1'b1, '0, 32'h2);
    tick();
    set_disp(5'd21, 6'd21, 1'b0, 6'd3, '0, 1'b1, '0, 32'h5);
    #1;
    check_eq("s6_x_dst", issue_dst_tag, 20);
    tick();
    set_disp(5'd23, 6'd23, 1'b0, 6'd3, '0, 1'b0, 6'd3, '0);
    issue_ready = 1'b0;
    #1;
    check_eq("s6_none_valid", issue_valid, 0);
    tick(); clr_disp(); set_cdb(1'b1, 6'd3, 32'h33); #1;
    check_eq("s6_cdb_valid", issue_valid, 0);
    check_eq("s6_occ", occupancy, 2);
    tick(); set_cdb(1'b0, '0, '0); #1;
    check_eq("s6_old_dst", issue_dst_tag, 21);
    check_eq("s6_old_src1", issue_src1, 32'h33);
    check_eq("s6_old_src2", issue_src2, 32'h5);
    issue_ready = 1'b1;
    tick(); #1;
    check_eq("s6_young_dst", issue_dst_tag, 23);
    check_eq("s6_young_src1", issue_src1, 32'h33);
    check_eq("s6_young_src2", issue_src2, 32'h33);
    tick(); #1;
    check_eq("s6_occ0", occupancy, 0);

    // S7a: flush with three entries and a competing dispatch
    issue_ready = 1'b0;
    for (int k = 11; k <= 13; k++) begin
      set_disp(OW'(k), TW'(k), 1'b1, '0, DW'(k), 1'b1, '0, DW'(k));
      tick();
    end
    clr_disp();
    #1;
    check_eq("s7_pre_occ", occupancy, 3);
    flush = 1'b1;
    issue_ready = 1'b1;
    set_disp(5'd14, 6'd14, 1'b1, '0, 32'h14, 1'b1, '0, 32'h14);
    #1;
    check_eq("s7_flush_ivalid", issue_valid, 0);
    check_eq("s7_flush_drdy", dispatch_ready, 0);
    check_eq("s7_flush_dst", issue_dst_tag, 0);
    tick(); flush = 1'b0; clr_disp(); #1;
    check_eq("s7_post_occ", occupancy, 0);
    check_eq("s7_post_ivalid", issue_valid, 0);
    check_eq("s7_post_drdy", dispatch_ready, 1);
    set_disp(5'd30, 6'd30, 1'b1, '0, 32'h30, 1'b1, '0, 32'h31);
    tick(); clr_disp(); #1;
    check_eq("s7_after_dst", issue_dst_tag, 30);
    tick(); #1;
    check_eq("s7_after_occ", occupancy, 0);

    // S7b: same with reset
    issue_ready = 1'b0;
    for (int k = 11; k <= 13; k++) begin
      set_disp(OW'(k), TW'(k), 1'b1, '0, DW'(k), 1'b1, '0, DW'(k));
      tick();
    end
    rst_n = 1'b0;
    issue_ready = 1'b1;
    set_disp(5'd14, 6'd14, 1'b1, '0, 32'h14, 1'b1, '0, 32'h14);
    #1;
    check_eq("s7r_drdy", dispatch_ready, 0);
    check_eq("s7r_ivalid", issue_valid, 0);
    check_eq("s7r_dst", issue_dst_tag, 0);
    check_eq("s7r_src1", issue_src1, 0);
    tick(); rst_n = 1'b1; clr_disp(); issue_ready = 1'b0; #1;
    check_eq("s7r_occ", occupancy, 0);
    check_eq("s7r_post_ivalid", issue_valid, 0);
    check_eq("s7r_post_drdy", dispatch_ready, 1);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
